// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry, parity helper
// and the host command bytes sent to the keyboard.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Host frame after the start bit: d0..d7, parity, stop.
    localparam int PS2_FRAME_BITS = 10;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line plus a falling-edge
// strobe; the line idles high, so the flops reset to 1.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign line_sync = sync_reg;
    assign line_fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, shifts one command byte
// out on device clock edges, collects the device ACK and reports done/timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12_000,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       key_clk_in,
    input  logic       key_data_in,
    output logic       key_clk_drive,
    output logic       key_data_drive,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    // Bit 0 is the clock line, bit 1 the data line.
    logic [1:0] line_raw;
    logic [1:0] line_sync;
    logic [1:0] line_fall;
    logic       clk_sync;
    logic       data_sync;
    logic       clk_fall;
    logic       unused_data_fall;

    assign line_raw = {key_data_in, key_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            ps2_line_sync u_sync (
                .clk       (clk),
                .reset     (reset),
                .line_in   (line_raw[gi]),
                .line_sync (line_sync[gi]),
                .line_fall (line_fall[gi])
            );
        end
    endgenerate

    assign clk_sync         = line_sync[0];
    assign data_sync        = line_sync[1];
    assign clk_fall         = line_fall[0];
    assign unused_data_fall = line_fall[1];

    ps2_tx_state_t             state_reg, state_next;
    logic [PS2_FRAME_BITS-1:0] frame_reg, frame_next;
    logic [3:0]                bit_idx_reg, bit_idx_next;
    logic [INH_W-1:0]          inh_cnt_reg, inh_cnt_next;
    logic [TMO_W-1:0]          tmo_cnt_reg, tmo_cnt_next;
    logic                      ack_reg, ack_next;
    logic                      clk_drive_reg, clk_drive_next;
    logic                      data_drive_reg, data_drive_next;
    logic                      ready_reg, ready_next;
    logic                      inhibit_reg, inhibit_next;
    logic                      done_reg, done_next;
    logic                      ack_ok_reg, ack_ok_next;
    logic                      error_reg, error_next;

    logic [INH_W-1:0] inh_inc;
    logic [TMO_W-1:0] tmo_inc;

    assign inh_inc = (inh_cnt_reg == INH_LAST) ? inh_cnt_reg : inh_cnt_reg + INH_W'(1);
    assign tmo_inc = (tmo_cnt_reg == TMO_LAST) ? tmo_cnt_reg : tmo_cnt_reg + TMO_W'(1);

    always_comb begin
        state_next      = state_reg;
        frame_next      = frame_reg;
        bit_idx_next    = bit_idx_reg;
        inh_cnt_next    = inh_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        ack_next        = ack_reg;
        clk_drive_next  = clk_drive_reg;
        data_drive_next = data_drive_reg;
        done_next       = 1'b0;
        ack_ok_next     = 1'b0;
        error_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    frame_next     = {1'b1, odd_parity(tx_data), tx_data};
                    inh_cnt_next   = INH_W'(1);
                    clk_drive_next = 1'b1;
                    state_next     = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt_reg >= INH_LAST) begin
                    clk_drive_next  = 1'b0;
                    data_drive_next = 1'b1;
                    bit_idx_next    = '0;
                    tmo_cnt_next    = '0;
                    state_next      = SHIFT;
                end else begin
                    inh_cnt_next = inh_inc;
                end
            end

            SHIFT, ACK, WAIT_IDLE: begin
                // The done/error pulse cycle keeps the block busy so tx_ready
                // rises only in the cycle after the pulse.
                if (done_reg || error_reg) begin
                    state_next = IDLE;
                end else if (clk_fall) begin
                    tmo_cnt_next = '0;
                    if (state_reg == SHIFT) begin
                        data_drive_next = ~frame_reg[0];
                        frame_next      = {1'b0, frame_reg[PS2_FRAME_BITS-1:1]};
                        bit_idx_next    = bit_idx_reg + 4'd1;
                        if (bit_idx_reg == LAST_BIT) begin
                            state_next = ACK;
                        end
                    end else if (state_reg == ACK) begin
                        ack_next   = ~data_sync;
                        state_next = WAIT_IDLE;
                    end
                end else if (state_reg == WAIT_IDLE && clk_sync && data_sync) begin
                    done_next   = 1'b1;
                    ack_ok_next = ack_reg;
                end else if (tmo_inc == TMO_LAST) begin
                    clk_drive_next  = 1'b0;
                    data_drive_next = 1'b0;
                    error_next      = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_inc;
                end
            end

            default: begin
                clk_drive_next  = 1'b0;
                data_drive_next = 1'b0;
                state_next      = IDLE;
            end
        endcase

        ready_next   = (state_next == IDLE);
        inhibit_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            frame_reg      <= '0;
            bit_idx_reg    <= '0;
            inh_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            ack_reg        <= 1'b0;
            clk_drive_reg  <= 1'b0;
            data_drive_reg <= 1'b0;
            ready_reg      <= 1'b1;
            inhibit_reg    <= 1'b0;
            done_reg       <= 1'b0;
            ack_ok_reg     <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_reg      <= frame_next;
            bit_idx_reg    <= bit_idx_next;
            inh_cnt_reg    <= inh_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            ack_reg        <= ack_next;
            clk_drive_reg  <= clk_drive_next;
            data_drive_reg <= data_drive_next;
            ready_reg      <= ready_next;
            inhibit_reg    <= inhibit_next;
            done_reg       <= done_next;
            ack_ok_reg     <= ack_ok_next;
            error_reg      <= error_next;
        end
    end

    assign tx_ready       = ready_reg;
    assign rx_inhibit     = inhibit_reg;
    assign key_clk_drive  = clk_drive_reg;
    assign key_data_drive = data_drive_reg;
    assign tx_done        = done_reg;
    assign tx_ack_ok      = ack_ok_reg;
    assign tx_error       = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: emulates a PS/2 device on the open-drain lines and
// compares every output each cycle against a transaction-level model.
module tb_ps2_host_tx;

    localparam int INH   = 120;
    localparam int TMO   = 1000;
    localparam int HALF  = 15;
    localparam int NEVER = 1_000_000_000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       key_clk_in;
    logic       key_data_in;
    logic       key_clk_drive;
    logic       key_data_drive;
    logic       rx_inhibit;
    logic       tx_done;
    logic       tx_ack_ok;
    logic       tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign key_clk_in  = ~(key_clk_drive | dev_clk_low);
    assign key_data_in = ~(key_data_drive | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .key_clk_in     (key_clk_in),
        .key_data_in    (key_data_in),
        .key_clk_drive  (key_clk_drive),
        .key_data_drive (key_data_drive),
        .rx_inhibit     (rx_inhibit),
        .tx_done        (tx_done),
        .tx_ack_ok      (tx_ack_ok),
        .tx_error       (tx_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_on = 1'b0;

    // Transaction model state
    int         acc_cyc = -1;
    int         end_cyc = NEVER;
    bit         end_is_reset = 1'b0;
    int         exp_done_cyc = -1;
    int         exp_err_cyc = -1;
    bit         exp_ack = 1'b0;
    logic [7:0] exp_data = 8'h00;
    int         fall_q[$];

    // Observations
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         clk_low_cnt = 0;
    int         shift_cyc = -1;
    int         err_seen_cyc = -1;
    logic       last_ack_ok = 1'b0;
    logic [9:0] dev_frame = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 ns after the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (model_on) begin
                bit busy, act, e_clk, e_dat, e_done, e_err;
                int drv_end, k;
                logic [9:0] ef;
                ef = {1'b1, ($countones(exp_data) % 2 == 0), exp_data};
                busy = (acc_cyc >= 0) && (cyc >= acc_cyc + 1) && (cyc <= end_cyc);
                drv_end = end_is_reset ? end_cyc + 1 : end_cyc;
                act = busy && (cyc < drv_end);
                e_clk = act && (cyc <= acc_cyc + INH);
                e_dat = 1'b0;
                if (act && cyc >= acc_cyc + INH + 1) begin
                    k = 0;
                    foreach (fall_q[i]) if (fall_q[i] <= cyc - 3) k++;
                    if (k == 0) e_dat = 1'b1;
                    else if (k <= 10) e_dat = ~ef[k-1];
                end
                e_done = (cyc == exp_done_cyc);
                e_err  = (cyc == exp_err_cyc);
                chk("tx_ready", {31'd0, tx_ready}, {31'd0, !busy});
                chk("rx_inhibit", {31'd0, rx_inhibit}, {31'd0, busy});
                chk("key_clk_drive", {31'd0, key_clk_drive}, {31'd0, e_clk});
                chk("key_data_drive", {31'd0, key_data_drive}, {31'd0, e_dat});
                chk("tx_done", {31'd0, tx_done}, {31'd0, e_done});
                chk("tx_ack_ok", {31'd0, tx_ack_ok}, {31'd0, e_done & exp_ack});
                chk("tx_error", {31'd0, tx_error}, {31'd0, e_err});
                if (tx_done) begin
                    done_cnt++;
                    last_ack_ok = tx_ack_ok;
                end
                if (tx_error) begin
                    err_cnt++;
                    err_seen_cyc = cyc;
                end
                if (key_clk_drive) clk_low_cnt++;
                if (key_data_drive && shift_cyc < 0) shift_cyc = cyc;
            end
        end
    end

    task automatic start_send(input logic [7:0] d);
        @(negedge clk);
        fall_q.delete();
        acc_cyc = cyc;
        end_cyc = NEVER;
        end_is_reset = 1'b0;
        exp_done_cyc = -1;
        exp_err_cyc = -1;
        exp_ack = 1'b0;
        exp_data = d;
        done_cnt = 0;
        err_cnt = 0;
        clk_low_cnt = 0;
        shift_cyc = -1;
        err_seen_cyc = -1;
        dev_frame = '0;
        tx_valid = 1'b1;
        tx_data = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device emulator: waits for the start bit, then clocks nfalls edges.
    // Returns with the clock held low if it stops before the 11th edge.
    task automatic device(input int nfalls, input bit do_ack);
        int t;
        t = 0;
        while (!(key_data_drive && !key_clk_drive) && t < INH + 200) begin
            @(negedge clk);
            t++;
        end
        chk("start_bit_seen", {31'd0, key_data_drive && !key_clk_drive}, 32'd1);
        if (nfalls == 0) return;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            fall_q.push_back(cyc);
            if (i == nfalls && nfalls < 11) return;
            repeat (HALF) @(negedge clk);
            if (i <= 10) dev_frame[i-1] = key_data_in;
            dev_clk_low = 1'b0;
            if (i == 10 && do_ack) dev_data_low = 1'b1;
            if (i == 11) begin
                if (do_ack) begin
                    repeat (5) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                exp_ack = do_ack;
                exp_done_cyc = cyc + 3;
                end_cyc = exp_done_cyc;
            end
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (cyc <= end_cyc + 1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", {31'd0, cyc > end_cyc + 1}, 32'd1);
    endtask

    logic [7:0] pc_data[3]  = '{8'h00, 8'hFF, 8'h01};
    logic [9:0] pc_frame[3] = '{10'h300, 10'h3FF, 10'h201};
    logic       pc_par[3]   = '{1'b1, 1'b1, 1'b0};

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_clk_drive", {31'd0, key_clk_drive}, 32'd0);
        chk("rst_data_drive", {31'd0, key_data_drive}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_tx_ack_ok", {31'd0, tx_ack_ok}, 32'd0);
        chk("rst_tx_error", {31'd0, tx_error}, 32'd0);
        reset = 1'b0;
        model_on = 1'b1;
        repeat (3) @(negedge clk);

        // 1: set-LEDs command, device ACKs
        start_send(ps2_pkg::PS2_CMD_SET_LED);
        device(11, 1'b1);
        wait_end();
        chk("t1_frame", {22'd0, dev_frame}, 32'h3ED);
        chk("t1_inhibit_len", clk_low_cnt, INH);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_ack_ok", {31'd0, last_ack_ok}, 32'd1);
        $display("txn 1 data=ED frame=%h done=%0d ack=%0d", dev_frame, done_cnt, last_ack_ok);

        // 2: parity corners
        for (int i = 0; i < 3; i++) begin
            start_send(pc_data[i]);
            device(11, 1'b1);
            wait_end();
            chk("t2_parity", {31'd0, dev_frame[8]}, {31'd0, pc_par[i]});
            chk("t2_frame", {22'd0, dev_frame}, {22'd0, pc_frame[i]});
            $display("txn 2.%0d data=%h parity=%0d", i, pc_data[i], dev_frame[8]);
        end

        // 3: NACK
        start_send(ps2_pkg::PS2_CMD_RESET);
        device(11, 1'b0);
        wait_end();
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_ack_ok", {31'd0, last_ack_ok}, 32'd0);
        chk("t3_err_cnt", err_cnt, 0);
        $display("txn 3 data=FF nack done=%0d ack=%0d err=%0d", done_cnt, last_ack_ok, err_cnt);

        // 4: device never clocks -> timeout
        start_send(ps2_pkg::PS2_CMD_ECHO);
        exp_err_cyc = acc_cyc + INH + 1 + TMO;
        end_cyc = exp_err_cyc;
        device(0, 1'b0);
        wait_end();
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_err_delay", err_seen_cyc - shift_cyc, TMO);
        $display("txn 4 timeout err=%0d delay=%0d", err_cnt, err_seen_cyc - shift_cyc);

        // 5: reset after the 5th falling edge, then a normal send
        start_send(ps2_pkg::PS2_CMD_SET_LED);
        device(5, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        end_cyc = cyc;
        end_is_reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        chk("t5_clk_released", {31'd0, key_clk_drive}, 32'd0);
        chk("t5_data_released", {31'd0, key_data_drive}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_pulses", done_cnt + err_cnt, 0);
        start_send(ps2_pkg::PS2_CMD_ENABLE);
        device(11, 1'b1);
        wait_end();
        chk("t5_frame", {22'd0, dev_frame}, 32'h2F4);
        chk("t5_done_cnt", done_cnt, 1);
        $display("txn 5 reset-abort then F4 frame=%h done=%0d", dev_frame, done_cnt);

        // 6: request during INHIBIT is ignored
        start_send(ps2_pkg::PS2_CMD_ECHO);
        repeat (10) @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h55;
        repeat (20) @(negedge clk);
        tx_valid = 1'b0;
        device(11, 1'b1);
        wait_end();
        repeat (20) @(negedge clk);
        chk("t6_frame", {22'd0, dev_frame}, 32'h3EE);
        chk("t6_done_cnt", done_cnt, 1);
        $display("txn 6 busy-ignore frame=%h done=%0d", dev_frame, done_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
